ram_access_ctrl: RTL

Front-end controller that turns board pushbuttons and switches into the write-port stimulus (`we`, `addr`, `din`) for the dual-RAM display block downstream. It debounces three raw keys, keeps an auto-incrementing address pointer, and issues single-cycle write strobes. After reset, or on request, it sweeps all 16 locations to zero. All outputs are registered and drive the RAM's `we`/`addr`/`din` inputs directly.

---
 rtl/ram_access_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ram_access_ctrl.sv
// Pushbutton/switch front end for the dual-RAM display block: debounces three keys,
// keeps an address pointer and emits registered write strobes, including a 16-entry clear sweep.
module ram_access_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_wr,
    input  logic       key_inc,
    input  logic       key_clr,
    input  logic [3:0] sw_addr,
    input  logic       sw_sel,
    input  logic [1:0] sw_data,
    output logic       we,
    output logic [3:0] addr,
    output logic [1:0] din,
    output logic [3:0] ptr,
    output logic       busy
);

    localparam int NK      = 3;
    localparam int KEY_WR  = 0;
    localparam int KEY_INC = 1;
    localparam int KEY_CLR = 2;
    localparam int CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {CLEAR, IDLE, WRITE} state_t;

    logic [NK-1:0] key_raw;
    logic [NK-1:0] sync_p0, sync_p1;
    logic [NK-1:0] level, level_d, pulse;
    logic [CW-1:0] db_cnt [NK];

    state_t     state, state_n;
    logic [4:0] clr_cnt, clr_cnt_n;
    logic       sel_q, sel_n;
    logic       we_n, busy_n;
    logic [3:0] addr_n, ptr_n;
    logic [1:0] din_n;

    assign key_raw = {key_clr, key_inc, key_wr};

    // Stage 0/1: synchronizer, stage 2: debounce level, stage 3: registered rising-edge pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            level   <= '0;
            level_d <= '0;
            pulse   <= '0;
            for (int k = 0; k < NK; k++) begin
                db_cnt[k] <= '0;
            end
        end else begin
            sync_p0 <= key_raw;
            sync_p1 <= sync_p0;
            level_d <= level;
            pulse   <= level & ~level_d;
            for (int k = 0; k < NK; k++) begin
                if (sync_p1[k] == level[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] == CNT_LAST) begin
                    db_cnt[k] <= '0;
                    level[k]  <= ~level[k];
                end else begin
                    db_cnt[k] <= db_cnt[k] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            sel_q   <= 1'b0;
            we      <= 1'b0;
            addr    <= '0;
            din     <= '0;
            ptr     <= '0;
            busy    <= 1'b1;
        end else begin
            state   <= state_n;
            clr_cnt <= clr_cnt_n;
            sel_q   <= sel_n;
            we      <= we_n;
            addr    <= addr_n;
            din     <= din_n;
            ptr     <= ptr_n;
            busy    <= busy_n;
        end
    end

    // Outputs are the registered image of the next-state values; key pulses are
    // only looked at in IDLE, so anything arriving during CLEAR or WRITE is dropped.
    always_comb begin
        state_n   = state;
        clr_cnt_n = clr_cnt;
        sel_n     = sel_q;
        we_n      = 1'b0;
        addr_n    = addr;
        din_n     = din;
        ptr_n     = ptr;
        busy_n    = 1'b0;
        unique case (state)
            CLEAR: begin
                busy_n = 1'b1;
                // clr_cnt[4] marks the extra cycle after address 15 is written
                if (clr_cnt[4]) begin
                    state_n   = IDLE;
                    busy_n    = 1'b0;
                    clr_cnt_n = '0;
                end else begin
                    we_n      = 1'b1;
                    addr_n    = clr_cnt[3:0];
                    din_n     = 2'b00;
                    clr_cnt_n = clr_cnt + 5'd1;
                end
            end
            IDLE: begin
                if (pulse[KEY_CLR]) begin
                    state_n   = CLEAR;
                    busy_n    = 1'b1;
                    clr_cnt_n = '0;
                end else if (pulse[KEY_WR]) begin
                    state_n = WRITE;
                    we_n    = 1'b1;
                    addr_n  = sw_sel ? ptr : sw_addr;
                    din_n   = sw_data;
                    sel_n   = sw_sel;
                end else if (pulse[KEY_INC]) begin
                    ptr_n = ptr + 4'd1;
                end
            end
            WRITE: begin
                state_n = IDLE;
                if (sel_q) begin
                    ptr_n = ptr + 4'd1;
                end
            end
            default: begin
                state_n   = CLEAR;
                busy_n    = 1'b1;
                clr_cnt_n = '0;
            end
        endcase
    end

endmodule
